// File: rtl/store_queue_v2_pkg.sv
// Shared types and helpers for the store queue: default-configuration entry/index
// types and the byte-lane width helper used to derive BE_W from DATA_W.
package store_queue_v2_pkg;

  localparam int unsigned SQ_DEPTH  = 8;
  localparam int unsigned SQ_ADDR_W = 32;
  localparam int unsigned SQ_DATA_W = 32;

  function automatic int unsigned sq_be_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  localparam int unsigned SQ_BE_W = sq_be_w(SQ_DATA_W);

  typedef logic [$clog2(SQ_DEPTH)-1:0] sq_idx_t;

  typedef struct packed {
    logic [SQ_ADDR_W-1:0] addr;
    logic [SQ_DATA_W-1:0] data;
    logic [SQ_BE_W-1:0]   be;
  } sq_entry_t;

endpackage

// File: rtl/sq_fwd_merge.sv
// Combinational store-to-load forwarding: scans live entries oldest to youngest so
// the youngest matching store wins each byte lane.
module sq_fwd_merge
  import store_queue_v2_pkg::*;
#(
  parameter  int unsigned DEPTH  = 8,
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned BE_W   = sq_be_w(DATA_W),
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] ent_addr [DEPTH],
  input  logic [DATA_W-1:0] ent_data [DEPTH],
  input  logic [BE_W-1:0]   ent_be   [DEPTH],
  input  logic [IDX_W-1:0]  head,
  input  logic [IDX_W:0]    cnt,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [BE_W-1:0]   fwd_hit
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(BE_W - 1));

  logic [IDX_W-1:0] idx;

  always_comb begin
    fwd_data = '0;
    fwd_hit  = '0;
    idx      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + IDX_W'(k);
      if ((k < 32'(cnt)) && (((ent_addr[idx] ^ fwd_addr) & WORD_MASK) == '0)) begin
        for (int unsigned b = 0; b < BE_W; b++) begin
          if (ent_be[idx][b]) begin
            fwd_data[b*8 +: 8] = ent_data[idx][b*8 +: 8];
            fwd_hit[b]         = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_queue_v2.sv
// Store queue between execute and the D-cache write port: in-order commit, drain,
// byte-merged forwarding and flush. Define STORE_QUEUE_PERF_EN for perf counters.
module store_queue_v2
  import store_queue_v2_pkg::*;
#(
  parameter  int unsigned DEPTH  = 8,
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned BE_W   = sq_be_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_st_valid,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic [DATA_W-1:0] i_st_data,
  input  logic [BE_W-1:0]   i_st_be,
  output logic              o_st_ready,
  input  logic              i_commit,
  input  logic [ADDR_W-1:0] i_fwd_addr,
  input  logic [BE_W-1:0]   i_fwd_be,
  output logic [DATA_W-1:0] o_fwd_data,
  output logic [BE_W-1:0]   o_fwd_hit,
  output logic              o_fwd_full,
  output logic              o_mem_valid,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  output logic [BE_W-1:0]   o_mem_be,
  input  logic              i_mem_ready,
  output logic              o_empty,
  output logic              o_commit_err
`ifdef STORE_QUEUE_PERF_EN
  ,
  output logic [31:0]       o_perf_inserts,
  output logic [31:0]       o_perf_full_stalls,
  output logic [31:0]       o_perf_fwd_full
`endif
);

  localparam int unsigned       IDX_W     = $clog2(DEPTH);
  localparam logic [IDX_W:0]    FULL_CNT  = (IDX_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(BE_W - 1));

  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [BE_W-1:0]   ent_be   [DEPTH];

  logic [IDX_W-1:0] head, cptr, tail, cptr_next;
  logic [IDX_W:0]   cnt, ccnt, cnt_next, ccnt_next;
  logic             commit_err;
  logic             ins, cmt, drn;

  assign o_st_ready   = (cnt != FULL_CNT);
  assign o_empty      = (cnt == '0);
  assign o_mem_valid  = (ccnt != '0);
  assign o_mem_addr   = ent_addr[head];
  assign o_mem_data   = ent_data[head];
  assign o_mem_be     = ent_be[head];
  assign o_commit_err = commit_err;

  // Flush drops a same-cycle insert; commit legality uses registered counts only.
  assign ins = i_st_valid && o_st_ready && !i_flush;
  assign cmt = i_commit && (ccnt != cnt);
  assign drn = o_mem_valid && i_mem_ready;

  assign cptr_next = cptr + IDX_W'(cmt);
  assign cnt_next  = cnt + {{IDX_W{1'b0}}, ins} - {{IDX_W{1'b0}}, drn};
  assign ccnt_next = ccnt + {{IDX_W{1'b0}}, cmt} - {{IDX_W{1'b0}}, drn};

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      cptr       <= '0;
      tail       <= '0;
      cnt        <= '0;
      ccnt       <= '0;
      commit_err <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_be[i]   <= '0;
      end
    end else begin
      if (ins) begin
        ent_addr[tail] <= i_st_addr & WORD_MASK;
        ent_data[tail] <= i_st_data;
        ent_be[tail]   <= i_st_be;
      end
      if (drn) head <= head + IDX_W'(1);
      cptr <= cptr_next;
      ccnt <= ccnt_next;
      // Flush rewinds tail onto the post-commit pointer so only committed stores survive.
      if (i_flush) begin
        tail <= cptr_next;
        cnt  <= ccnt_next;
      end else begin
        tail <= tail + IDX_W'(ins);
        cnt  <= cnt_next;
      end
      if (i_commit && !cmt) commit_err <= 1'b1;
    end
  end

  sq_fwd_merge #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd_merge (
    .ent_addr (ent_addr),
    .ent_data (ent_data),
    .ent_be   (ent_be),
    .head     (head),
    .cnt      (cnt),
    .fwd_addr (i_fwd_addr),
    .fwd_data (o_fwd_data),
    .fwd_hit  (o_fwd_hit)
  );

  assign o_fwd_full = ((o_fwd_hit & i_fwd_be) == i_fwd_be) && (i_fwd_be != '0);

`ifdef STORE_QUEUE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_perf_inserts     <= '0;
      o_perf_full_stalls <= '0;
      o_perf_fwd_full    <= '0;
    end else begin
      if (ins && (o_perf_inserts != '1)) o_perf_inserts <= o_perf_inserts + 32'd1;
      if (i_st_valid && !o_st_ready && (o_perf_full_stalls != '1))
        o_perf_full_stalls <= o_perf_full_stalls + 32'd1;
      if (o_fwd_full && (o_perf_fwd_full != '1)) o_perf_fwd_full <= o_perf_fwd_full + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_store_queue_v2.sv
// Scenario-driven bench for store_queue_v2 with a drain scoreboard and a small
// behavioural model of occupancy, commit and flush.
module tb_store_queue_v2;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_flush = 1'b0, i_st_valid = 1'b0, i_commit = 1'b0, i_mem_ready = 1'b0;
  logic [31:0] i_st_addr = '0, i_st_data = '0, i_fwd_addr = '0;
  logic [3:0]  i_st_be = '0, i_fwd_be = 4'hf;
  logic        o_st_ready, o_fwd_full, o_mem_valid, o_empty, o_commit_err;
  logic [31:0] o_fwd_data, o_mem_addr, o_mem_data;
  logic [3:0]  o_fwd_hit, o_mem_be;
`ifdef STORE_QUEUE_PERF_EN
  logic [31:0] o_perf_inserts, o_perf_full_stalls, o_perf_fwd_full;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t sb[$];
  int   mccnt = 0;
  bit   merr  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  store_queue_v2 #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (i_flush),
    .i_st_valid   (i_st_valid),
    .i_st_addr    (i_st_addr),
    .i_st_data    (i_st_data),
    .i_st_be      (i_st_be),
    .o_st_ready   (o_st_ready),
    .i_commit     (i_commit),
    .i_fwd_addr   (i_fwd_addr),
    .i_fwd_be     (i_fwd_be),
    .o_fwd_data   (o_fwd_data),
    .o_fwd_hit    (o_fwd_hit),
    .o_fwd_full   (o_fwd_full),
    .o_mem_valid  (o_mem_valid),
    .o_mem_addr   (o_mem_addr),
    .o_mem_data   (o_mem_data),
    .o_mem_be     (o_mem_be),
    .i_mem_ready  (i_mem_ready),
    .o_empty      (o_empty),
    .o_commit_err (o_commit_err)
`ifdef STORE_QUEUE_PERF_EN
    ,
    .o_perf_inserts     (o_perf_inserts),
    .o_perf_full_stalls (o_perf_full_stalls),
    .o_perf_fwd_full    (o_perf_fwd_full)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard side: every handshake must present the oldest committed model entry.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (o_mem_valid !== (mccnt != 0)) begin
        errors++;
        $display("FAIL mem_valid got %0b exp %0b", o_mem_valid, mccnt != 0);
      end
      checks++;
      if (o_st_ready !== (sb.size() != DEPTH)) begin
        errors++;
        $display("FAIL st_ready got %0b exp %0b", o_st_ready, sb.size() != DEPTH);
      end
      if (o_mem_valid === 1'b1 && i_mem_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL drain_empty got addr %h exp no request", o_mem_addr);
        end else if (o_mem_addr !== sb[0].addr || o_mem_data !== sb[0].data || o_mem_be !== sb[0].be) begin
          errors++;
          $display("FAIL drain got %h/%h/%h exp %h/%h/%h", o_mem_addr, o_mem_data, o_mem_be,
                   sb[0].addr, sb[0].data, sb[0].be);
        end
      end
    end
  end

  function automatic void fwd_model(input logic [31:0] a, output logic [31:0] d, output logic [3:0] h);
    d = '0;
    h = '0;
    foreach (sb[k]) begin
      if (sb[k].addr[31:2] == a[31:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (sb[k].be[b]) begin
            d[b*8 +: 8] = sb[k].data[b*8 +: 8];
            h[b] = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    i_st_valid = 1'b0; i_commit = 1'b0; i_flush = 1'b0; i_mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    mccnt = 0;
    merr = 1'b0;
  endtask

  task automatic tick(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input bit c, input bit f, input bit r);
    int  pre_cnt, pre_ccnt;
    bit  ins, cmt, drn;
    ent_t e;
    i_st_valid = v; i_st_addr = a; i_st_data = d; i_st_be = be;
    i_commit = c; i_flush = f; i_mem_ready = r;
    pre_cnt  = sb.size();
    pre_ccnt = mccnt;
    ins = v && (pre_cnt != DEPTH) && !f;
    cmt = c && (pre_ccnt < pre_cnt);
    drn = r && (pre_ccnt != 0);
    if (c && !cmt) merr = 1'b1;
    @(posedge clk); #1;
    if (drn) void'(sb.pop_front());
    mccnt = pre_ccnt + int'(cmt) - int'(drn);
    if (ins) begin
      e.addr = a & 32'hffff_fffc; e.data = d; e.be = be;
      sb.push_back(e);
    end
    if (f) while (sb.size() > mccnt) void'(sb.pop_back());
    i_st_valid = 1'b0; i_commit = 1'b0; i_flush = 1'b0; i_mem_ready = 1'b0;
  endtask

  task automatic drain_all();
    for (int n = 0; n < 64 && sb.size() != 0; n++) tick(0, '0, '0, '0, mccnt < sb.size(), 0, 1);
    checks++;
    if (o_empty !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL drain_all_timeout got empty=%0b exp 1 (model left %0d)", o_empty, sb.size());
    end
  endtask

  task automatic test_reset();
    i_fwd_addr = '0; i_fwd_be = 4'hf;
    do_reset();
    checks += 6;
    if (o_st_ready !== 1'b1)   begin errors++; $display("FAIL rst_ready got %0b exp 1", o_st_ready); end
    if (o_mem_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid got %0b exp 0", o_mem_valid); end
    if (o_empty !== 1'b1)      begin errors++; $display("FAIL rst_empty got %0b exp 1", o_empty); end
    if (o_fwd_hit !== 4'h0)    begin errors++; $display("FAIL rst_hit got %h exp 0", o_fwd_hit); end
    if (o_fwd_data !== 32'h0)  begin errors++; $display("FAIL rst_fwd_data got %h exp 0", o_fwd_data); end
    if (o_commit_err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", o_commit_err); end
  endtask

  task automatic test_drain_basic();
    tick(1, 32'h100, 32'hAABBCCDD, 4'hf, 0, 0, 1);
    checks++;
    if (o_mem_valid !== 1'b0 || o_empty !== 1'b0) begin
      errors++; $display("FAIL basic_uncommitted got valid=%0b empty=%0b exp 0/0", o_mem_valid, o_empty);
    end
    tick(0, '0, '0, '0, 1, 0, 1);
    checks++;
    if (o_mem_valid !== 1'b1 || o_mem_addr !== 32'h100 || o_mem_data !== 32'hAABBCCDD) begin
      errors++; $display("FAIL basic_req got %0b/%h/%h exp 1/100/aabbccdd", o_mem_valid, o_mem_addr, o_mem_data);
    end
    tick(0, '0, '0, '0, 0, 0, 1);
    checks++;
    if (o_empty !== 1'b1 || o_mem_valid !== 1'b0) begin
      errors++; $display("FAIL basic_done got empty=%0b valid=%0b exp 1/0", o_empty, o_mem_valid);
    end
  endtask

  task automatic test_fwd_merge();
    do_reset();
    tick(1, 32'h200, 32'h0000_1111, 4'b0011, 0, 0, 0);
    tick(1, 32'h200, 32'h0022_2200, 4'b0110, 0, 0, 0);
    i_fwd_addr = 32'h202; i_fwd_be = 4'hf; #1;
    checks++;
    if (o_fwd_hit !== 4'b0111 || o_fwd_data !== 32'h0022_2211 || o_fwd_full !== 1'b0) begin
      errors++; $display("FAIL fwd_merge got %h/%h/%0b exp 7/00222211/0", o_fwd_hit, o_fwd_data, o_fwd_full);
    end
    i_fwd_be = 4'b0011; #1;
    checks++;
    if (o_fwd_full !== 1'b1) begin errors++; $display("FAIL fwd_full got %0b exp 1", o_fwd_full); end
    i_fwd_be = 4'b0000; #1;
    checks++;
    if (o_fwd_full !== 1'b0) begin errors++; $display("FAIL fwd_full_zero_be got %0b exp 0", o_fwd_full); end
    i_fwd_addr = 32'h204; i_fwd_be = 4'hf; #1;
    checks++;
    if (o_fwd_hit !== 4'h0 || o_fwd_data !== 32'h0) begin
      errors++; $display("FAIL fwd_miss got %h/%h exp 0/0", o_fwd_hit, o_fwd_data);
    end
    tick(0, '0, '0, '0, 1, 0, 0);
    tick(0, '0, '0, '0, 1, 0, 0);
    i_fwd_addr = 32'h200; i_mem_ready = 1'b1; #1;
    checks++;
    if (o_fwd_hit !== 4'b0111) begin errors++; $display("FAIL fwd_while_drain got %h exp 7", o_fwd_hit); end
    drain_all();
    checks++;
    if (o_fwd_hit !== 4'h0) begin errors++; $display("FAIL fwd_after_drain got %h exp 0", o_fwd_hit); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] ed;
    logic [3:0]  eh;
    do_reset();
    for (int i = 0; i < DEPTH; i++) tick(1, 32'h1000 + 32'(4*i), 32'h10 + 32'(i), 4'hf, 0, 0, 0);
    checks++;
    if (o_st_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", o_st_ready); end
    tick(1, 32'h2000, 32'h99, 4'hf, 0, 0, 0);
    i_fwd_addr = 32'h2000; #1;
    checks++;
    if (o_fwd_hit !== 4'h0) begin errors++; $display("FAIL full_reject got %h exp 0", o_fwd_hit); end
    for (int i = 0; i < 3; i++) tick(0, '0, '0, '0, 1, 0, 0);
    i_mem_ready = 1'b1; #1;
    checks++;
    if (o_st_ready !== 1'b0) begin errors++; $display("FAIL full_drain_cycle_ready got %0b exp 0", o_st_ready); end
    tick(0, '0, '0, '0, 0, 0, 1);
    checks++;
    if (o_st_ready !== 1'b1) begin errors++; $display("FAIL after_drain_ready got %0b exp 1", o_st_ready); end
    tick(0, '0, '0, '0, 0, 0, 1);
    tick(0, '0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 16; i++)
      tick(1, 32'h3000 + 32'(4*i), $urandom, 4'($urandom_range(0, 15)), 1, 0, 1);
    fwd_model(32'h303C, ed, eh);
    i_fwd_addr = 32'h303C; #1;
    checks++;
    if (o_fwd_hit !== eh || (o_fwd_data & {{8{eh[3]}}, {8{eh[2]}}, {8{eh[1]}}, {8{eh[0]}}}) !== ed) begin
      errors++; $display("FAIL wrap_fwd got %h/%h exp %h/%h", o_fwd_hit, o_fwd_data, eh, ed);
    end
    drain_all();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 32'h400 + 32'(4*i), 32'hA0 + 32'(i), 4'hf, 0, 0, 0);
    tick(0, '0, '0, '0, 1, 0, 0);
    tick(0, '0, '0, '0, 1, 0, 0);
    tick(1, 32'h4F0, 32'hDEAD, 4'hf, 1, 1, 0);
    i_fwd_addr = 32'h40C; #1;
    checks++;
    if (o_fwd_hit !== 4'h0 || o_empty !== 1'b0) begin
      errors++; $display("FAIL flush_drop got hit=%h empty=%0b exp 0/0", o_fwd_hit, o_empty);
    end
    i_fwd_addr = 32'h4F0; #1;
    checks++;
    if (o_fwd_hit !== 4'h0) begin errors++; $display("FAIL flush_insert_dropped got %h exp 0", o_fwd_hit); end
    i_fwd_addr = 32'h408; #1;
    checks++;
    if (o_fwd_hit !== 4'hf || o_fwd_data !== 32'hA2) begin
      errors++; $display("FAIL flush_keeps_committed got %h/%h exp f/a2", o_fwd_hit, o_fwd_data);
    end
    tick(1, 32'h500, 32'h55, 4'hf, 0, 0, 0);
    i_fwd_addr = 32'h500; #1;
    checks++;
    if (o_fwd_hit !== 4'hf || o_fwd_data !== 32'h55) begin
      errors++; $display("FAIL post_flush_insert got %h/%h exp f/55", o_fwd_hit, o_fwd_data);
    end
    drain_all();
  endtask

  task automatic test_commit_err();
    do_reset();
    tick(0, '0, '0, '0, 1, 0, 0);
    checks++;
    if (o_commit_err !== merr || merr !== 1'b1) begin
      errors++; $display("FAIL commit_err_set got %0b exp 1", o_commit_err);
    end
    tick(1, 32'h800, 32'h1, 4'h1, 0, 0, 0);
    tick(0, '0, '0, '0, 0, 0, 0);
    checks++;
    if (o_commit_err !== 1'b1) begin errors++; $display("FAIL commit_err_held got %0b exp 1", o_commit_err); end
    do_reset();
    checks++;
    if (o_commit_err !== 1'b0) begin errors++; $display("FAIL commit_err_clear got %0b exp 0", o_commit_err); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(1, 32'h600, 32'h66, 4'h5, 0, 0, 0);
    tick(1, 32'h604, 32'h77, 4'hA, 0, 0, 0);
    tick(0, '0, '0, '0, 1, 0, 0);
    tick(0, '0, '0, '0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, '0, '0, '0, 0, 0, 0);
      checks++;
      if (o_mem_valid !== 1'b1 || o_mem_addr !== 32'h600 || o_mem_data !== 32'h66 || o_mem_be !== 4'h5) begin
        errors++; $display("FAIL stall_hold got %0b/%h/%h/%h exp 1/600/66/5", o_mem_valid, o_mem_addr, o_mem_data, o_mem_be);
      end
    end
    for (int i = 0; i < 5; i++) tick(1, 32'h680 + 32'(4*i), 32'(i), 4'hf, 0, 0, 0);
    tick(1, 32'h700, 32'h70, 4'hf, 0, 0, 1);
    checks++;
    if (o_st_ready !== 1'b1 || o_mem_addr !== 32'h604) begin
      errors++; $display("FAIL ins_drain_cnt7 got ready=%0b addr=%h exp 1/604", o_st_ready, o_mem_addr);
    end
    tick(1, 32'h704, 32'h71, 4'hf, 0, 0, 0);
    checks++;
    if (o_st_ready !== 1'b0) begin errors++; $display("FAIL cnt7_plus_one got %0b exp 0", o_st_ready); end
    drain_all();
  endtask

  initial begin
    test_reset();
    test_drain_basic();
    test_fwd_merge();
    test_full_wrap();
    test_flush();
    test_commit_err();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
